// File: rtl/approx_alu_pkg.sv
// approx_alu_pkg: mode codes and FSM states shared by the ALU and the approximation control FSM.
package approx_alu_pkg;
  localparam logic [2:0] ADD_ONE  = 3'd0;
  localparam logic [2:0] SUB_ONE  = 3'd1;
  localparam logic [2:0] ADD_SUB  = 3'd2;
  localparam logic [2:0] MULTIPLY = 3'd3;
  localparam logic [2:0] ALU_IDLE = 3'd4;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/approx_alu_seq_shift_add_mul.sv
// shift_add_mul: iterative shift-add multiplier, one bit of B per cycle, LSB first.
// done_o flags the last iteration; prod_o holds the full product from the following cycle.
module shift_add_mul #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic                 done_o,
  output logic [2*WIDTH-1:0]   prod_o
);
  localparam int CW = $clog2(WIDTH);
  logic [2*WIDTH-1:0] acc_q, acc_d, a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic run_q, run_d;
  always_comb begin
    acc_d = acc_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    run_d = run_q;
    if (start_i) begin
      acc_d = '0;
      a_d = {{WIDTH{1'b0}}, a_i};
      b_d = b_i;
      cnt_d = '0;
      run_d = 1'b1;
    end else if (run_q) begin
      acc_d = b_q[0] ? acc_q + a_q : acc_q;
      a_d = a_q << 1;
      b_d = b_q >> 1;
      cnt_d = cnt_q + 1'b1;
      run_d = cnt_q != CW'(WIDTH - 1);
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt_q <= '0;
      run_q <= 1'b0;
    end else begin
      acc_q <= acc_d;
      a_q <= a_d;
      b_q <= b_d;
      cnt_q <= cnt_d;
      run_q <= run_d;
    end
  end
  assign done_o = run_q && cnt_q == CW'(WIDTH - 1);
  assign prod_o = acc_q;
endmodule

// File: rtl/approx_alu_seq.sv
// approx_alu_seq: registered approximation ALU with inc/dec, add/sub and iterative fixed-point multiply.
// Single-cycle ops write at the accept edge; multiply runs IDLE -> MUL (WIDTH edges) -> DONE -> IDLE.
module approx_alu_seq
  import approx_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int FRAC  = 4,
  parameter int SAT   = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  input  logic [2:0]       mode_i,
  input  logic [WIDTH-1:0] op_a_i,
  input  logic [WIDTH-1:0] op_b_i,
  input  logic             sigma_n_i,
  output logic             busy_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] res_o,
  output logic             ovf_o
);
  state_e state_q, state_d;
  logic valid_q, valid_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic accept, single, mul_start, mul_done, alu_sub, alu_ovf, mul_ovf;
  logic [WIDTH:0] a_x, b_x, alu;
  logic [WIDTH-1:0] alu_res, mul_res;
  logic [2*WIDTH-1:0] prod, prod_sh;
  shift_add_mul #(.WIDTH(WIDTH)) u_mul (
    .clk(clk),
    .rst(rst),
    .start_i(mul_start),
    .a_i(op_a_i),
    .b_i(op_b_i),
    .done_o(mul_done),
    .prod_o(prod)
  );
  always_comb begin
    accept = valid_i && state_q == IDLE;
    mul_start = accept && mode_i == MULTIPLY;
    single = accept && mode_i != MULTIPLY;
    a_x = {1'b0, op_a_i};
    b_x = {1'b0, op_b_i};
    alu_sub = mode_i == SUB_ONE || (mode_i == ADD_SUB && sigma_n_i);
    // bit WIDTH is the carry for additions and the borrow for subtractions
    alu = mode_i >= ALU_IDLE ? '0 :
          mode_i == ADD_ONE ? a_x + 1'b1 :
          mode_i == SUB_ONE ? a_x - 1'b1 :
          sigma_n_i ? a_x - b_x : a_x + b_x;
    alu_ovf = alu[WIDTH];
    alu_res = (SAT != 0 && alu_ovf) ? (alu_sub ? '0 : '1) : alu[WIDTH-1:0];
    prod_sh = prod >> FRAC;
    mul_ovf = |prod_sh[2*WIDTH-1:WIDTH];
    mul_res = (SAT != 0 && mul_ovf) ? '1 : prod_sh[WIDTH-1:0];
    state_d = state_q == IDLE ? (mul_start ? MUL : IDLE) :
              state_q == MUL ? (mul_done ? DONE : MUL) : IDLE;
    valid_d = single || state_q == DONE;
    res_d = single ? alu_res : state_q == DONE ? mul_res : res_q;
    ovf_d = single ? alu_ovf : state_q == DONE ? mul_ovf : ovf_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      res_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
    end
  end
  assign busy_o = state_q != IDLE;
  assign valid_o = valid_q;
  assign res_o = res_q;
  assign ovf_o = ovf_q;
endmodule

// File: tb/tb_approx_alu_seq.sv
// tb_approx_alu_seq: random and directed ops on wrap and saturating instances against an arithmetic model.
module tb_approx_alu_seq;
  localparam int W = 8;
  localparam int F = 4;
  logic clk = 1'b0, rst = 1'b0, valid_i = 1'b0, sigma_n_i = 1'b0;
  logic [2:0] mode_i = '0;
  logic [W-1:0] op_a_i = '0, op_b_i = '0;
  logic busy0, valid0, ovf0, busy1, valid1, ovf1;
  logic [W-1:0] res0, res1;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  approx_alu_seq #(.WIDTH(W), .FRAC(F), .SAT(0)) dut0 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mode_i(mode_i), .op_a_i(op_a_i),
    .op_b_i(op_b_i), .sigma_n_i(sigma_n_i), .busy_o(busy0), .valid_o(valid0),
    .res_o(res0), .ovf_o(ovf0)
  );
  approx_alu_seq #(.WIDTH(W), .FRAC(F), .SAT(1)) dut1 (
    .clk(clk), .rst(rst), .valid_i(valid_i), .mode_i(mode_i), .op_a_i(op_a_i),
    .op_b_i(op_b_i), .sigma_n_i(sigma_n_i), .busy_o(busy1), .valid_o(valid1),
    .res_o(res1), .ovf_o(ovf1)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // returns {ovf, res}
  function automatic logic [W:0] model(input int mode, input int a, input int b, input bit sig, input bit sat);
    int t;
    bit o;
    case (mode)
      0: begin t = a + 1; o = t > 255; end
      1: begin t = a - 1; o = a == 0; end
      2: begin t = sig ? a - b : a + b; o = sig ? b > a : t > 255; end
      3: begin t = (a * b) >> F; o = t > 255; end
      default: begin t = 0; o = 0; end
    endcase
    if (o && sat) t = t < 0 ? 0 : 255;
    return {o, W'(t)};
  endfunction
  task automatic check_both(input string tag, input logic [W:0] e0, input logic [W:0] e1);
    chk({tag, "_res"}, 32'(res0), 32'(e0[W-1:0]));
    chk({tag, "_ovf"}, 32'(ovf0), 32'(e0[W]));
    chk({tag, "_res_sat"}, 32'(res1), 32'(e1[W-1:0]));
    chk({tag, "_ovf_sat"}, 32'(ovf1), 32'(e1[W]));
  endtask
  task automatic run_op(input int mode, input int a, input int b, input bit sig, input bit b2b);
    logic [W:0] e0, e1;
    int lat, a2;
    bit busy_ok;
    e0 = model(mode, a, b, sig, 0);
    e1 = model(mode, a, b, sig, 1);
    valid_i = 1'b1;
    mode_i = 3'(mode);
    op_a_i = W'(a);
    op_b_i = W'(b);
    sigma_n_i = sig;
    @(posedge clk); #1;
    lat = 1;
    busy_ok = 1'b1;
    while (!valid0 && lat < 40) begin
      busy_ok = busy_ok & busy0 & busy1;
      mode_i = 3'($urandom);
      op_a_i = W'($urandom);
      op_b_i = W'($urandom);
      sigma_n_i = 1'($urandom);
      @(posedge clk); #1;
      lat++;
    end
    valid_i = 1'b0;
    chk("latency", 32'(lat), 32'(mode == 3 ? W + 2 : 1));
    chk("valid_sat", 32'(valid1), 32'd1);
    check_both("op", e0, e1);
    if (mode == 3) begin
      chk("busy_during_mul", 32'(busy_ok), 32'd1);
      chk("busy_at_valid", 32'(busy0), 32'd0);
    end
    if (b2b) begin
      a2 = int'($urandom_range(0, 255));
      e0 = model(0, a2, 0, 0, 0);
      e1 = model(0, a2, 0, 0, 1);
      valid_i = 1'b1;
      mode_i = 3'd0;
      op_a_i = W'(a2);
      @(posedge clk); #1;
      valid_i = 1'b0;
      chk("b2b_valid", 32'(valid0), 32'd1);
      check_both("b2b", e0, e1);
    end else begin
      @(posedge clk); #1;
      chk("pulse_end", 32'(valid0), 32'd0);
      chk("hold_res", 32'(res0), 32'(e0[W-1:0]));
    end
  endtask
  initial begin
    int pulses;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_valid", 32'(valid0), 32'd0);
    check_both("rst", '0, '0);
    rst = 1'b1;
    run_op(0, 'h7F, 0, 0, 0);
    run_op(0, 'hFF, 0, 0, 0);
    run_op(1, 'h00, 0, 0, 0);
    run_op(2, 'h10, 'h20, 1, 0);
    run_op(2, 'h10, 'h20, 0, 0);
    run_op(2, 'hF0, 'h20, 0, 0);
    run_op(5, 'h33, 'h44, 0, 0);
    run_op(3, 'h30, 'h20, 0, 0);
    run_op(3, 'hF0, 'hF0, 0, 1);
    run_op(3, 'hFF, 'h00, 0, 0);
    repeat (60)
      run_op(int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom));
    run_op(0, 'h7F, 0, 0, 0);
    valid_i = 1'b1;
    mode_i = 3'd3;
    op_a_i = 8'hF0;
    op_b_i = 8'hF0;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("abort_busy_before", 32'(busy0), 32'd1);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("abort_busy", 32'(busy0 | busy1), 32'd0);
    chk("abort_valid", 32'(valid0 | valid1), 32'd0);
    check_both("abort", '0, '0);
    rst = 1'b1;
    pulses = 0;
    repeat (15) begin
      @(posedge clk); #1;
      pulses += int'(valid0 | valid1);
    end
    chk("abort_no_valid", 32'(pulses), 32'd0);
    run_op(3, 'h30, 'h20, 0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
